mips_pipeline_mem_access_ctrl: RTL and testbench
================================================

# mips_pipeline_mem_access_ctrl

Sequences the MEM stage of the pipelined MIPS core against a multi-cycle data memory with a req/ack handshake. Each load or store held in the EX/MEM register becomes exactly one memory transaction. While the transaction is in flight, the block freezes the front of the pipeline and feeds bubbles into MEM/WB. Its read-data output is the `memOut` word consumed by the MEM/WB pipeline generator.

## Interface
Parameters:
- `TIMEOUT`, 64: maximum cycles in WAIT before an unacknowledged request aborts; legal range 2..65535.

Ports:
- `clock`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `exMemValid`  in  1: EX/MEM holds a live instruction.
- `memRead`  in  1: EX/MEM control bit for a load.
- `memWrite`  in  1: EX/MEM control bit for a store.
- `addr`  in  32: ALU result from EX/MEM, used as the byte address.
- `wdata`  in  32: store data from EX/MEM.
- `dmemReq`  out  1: request to data memory, registered.
- `dmemWe`  out  1: 1 = write, 0 = read; valid while `dmemReq`=1.
- `dmemAddr`  out  32: latched address, registered.
- `dmemWdata`  out  32: latched store data, registered.
- `dmemAck`  in  1: memory completion strobe, one cycle wide.
- `dmemRdata`  in  32: read data, valid in the cycle where `dmemAck`=1.
- `stall`  out  1: holds PC, IF/ID, ID/EX and EX/MEM.
- `memWbBubble`  out  1: forces MEM/WB control fields to zero this cycle.
- `memOut`  out  32: data word delivered to MEM/WB.
- `memError`  out  1: sticky timeout flag.

## Operation
- Memory op: `exMemValid & (memRead | memWrite)`. If both `memRead` and `memWrite` are set, the op is treated as a write.
- States: IDLE, WAIT, DONE, ERR. State is registered.
- IDLE:
  - No memory op: `stall`=0, `memWbBubble`=0, `memOut`=0. The instruction passes through.
  - Memory op: `stall`=1 and `memWbBubble`=1, both combinational. Latch `addr`, `wdata` and write-ness into `dmemAddr`, `dmemWdata` and `dmemWe`. Set `dmemReq`=1 and clear the timeout counter. Next state is WAIT.
- WAIT:
  - `stall`=1, `memWbBubble`=1, `dmemReq`=1.
  - `dmemAddr`, `dmemWdata` and `dmemWe` stay stable.
  - Counter increments each cycle.
  - On `dmemAck`=1: latch `dmemRdata` into the data register (latch 0 for writes), drop `dmemReq`, go to DONE.
  - Else, when the counter reaches `TIMEOUT`-1: drop `dmemReq`, set `memError`, go to ERR.
  - Ack and timeout in the same cycle: ack wins.
- DONE:
  - `stall`=0, `memWbBubble`=0, `memOut` = data register.
  - The instruction advances into MEM/WB this cycle.
  - Next state is IDLE unconditionally. A back-to-back memory op is therefore detected in the following IDLE cycle, never re-issued for the same instruction.
- ERR:
  - `stall`=1, `memWbBubble`=1, `dmemReq`=0, `memError`=1.
  - Leaves only on `reset`.
- `dmemAck` outside WAIT is ignored, including a stale ack after reset.
- Width rules: counter is 16 bits and never wraps in WAIT, because the timeout fires first. Addresses and data are passed through unmodified; no alignment checks.

## Timing
- Reset values: state IDLE; `dmemReq`=0, `dmemWe`=0, `dmemAddr`=0, `dmemWdata`=0; data register 0; counter 0; `memError`=0. Combinational outputs then follow the IDLE rules.
- Reset asserted in any state, including mid-WAIT, takes effect on the next edge: `dmemReq`=0 and the transaction is abandoned.
- Non-memory instruction: zero added latency.
- Memory op with ack in the k-th WAIT cycle (k≥1): `stall` is high for 1+k cycles, and DONE occurs 1+k cycles after detection. The minimum is 2 stall cycles.
- `dmemReq` rises one cycle after detection and falls on the edge after ack.
- `memOut` is valid only in DONE. Downstream samples it on the same edge as MEM/WB.

## Test plan
- Non-memory flow: `exMemValid`=1, `memRead`=`memWrite`=0 for 5 cycles -> `stall`=0, `dmemReq`=0, `memOut`=0 every cycle.
- Load, ack in the first WAIT cycle: `addr`=0x100, `dmemRdata`=0xDEADBEEF -> `dmemReq` high 1 cycle with `dmemAddr`=0x100 and `dmemWe`=0; `stall` high 2 cycles; DONE `memOut`=0xDEADBEEF.
- Store, ack after 3 cycles: `addr`=0x2004, `wdata`=0x12345678 -> `dmemWe`=1 and `dmemWdata` stable for all 3 cycles; `stall` high 4 cycles; DONE `memOut`=0.
- Back-to-back loads: two consecutive loads, each acked immediately -> exactly two requests, one per load; 0x100 then 0x104; no duplicate request in DONE.
- Timeout: `TIMEOUT`=4, load, no ack -> `dmemReq` high for 4 cycles, then `memError`=1 and `stall`=1 held. A late `dmemAck` is ignored. Reset clears everything.
- Reset mid-WAIT: reset asserted in cycle 2 of WAIT, ack pulsed the cycle after -> `dmemReq`=0 after the edge; state IDLE; `memOut`=0; ack ignored.

Source files
------------

// File: rtl/mips_pipeline_mem_access_ctrl.sv
// MEM-stage sequencer: turns each load/store in EX/MEM into one req/ack transaction
// with a multi-cycle data memory, stalling the front end and bubbling MEM/WB meanwhile.
module mips_pipeline_mem_access_ctrl #(
  parameter int TIMEOUT = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        exMemValid,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        dmemReq,
  output logic        dmemWe,
  output logic [31:0] dmemAddr,
  output logic [31:0] dmemWdata,
  input  logic        dmemAck,
  input  logic [31:0] dmemRdata,
  output logic        stall,
  output logic        memWbBubble,
  output logic [31:0] memOut,
  output logic        memError
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_ERR} state_t;

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

  state_t      state, state_next;
  logic [15:0] cnt;
  logic [31:0] data_q;
  logic        mem_op;
  logic        timeout_hit;

  assign mem_op      = exMemValid & (memRead | memWrite);
  assign timeout_hit = (cnt == TIMEOUT_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // NOTE: every comb output gets a default first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (mem_op) state_next = S_WAIT;
      S_WAIT:  begin
        if (dmemAck)          state_next = S_DONE;
        else if (timeout_hit) state_next = S_ERR;
      end
      S_DONE:  state_next = S_IDLE;
      S_ERR:   state_next = S_ERR;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    stall       = 1'b0;
    memWbBubble = 1'b0;
    memOut      = 32'h0;
    case (state)
      S_IDLE: begin
        stall       = mem_op;
        memWbBubble = mem_op;
      end
      S_WAIT, S_ERR: begin
        stall       = 1'b1;
        memWbBubble = 1'b1;
      end
      S_DONE:  memOut = data_q;
      default: ;
    endcase
  end

  // Transaction datapath: request, latched operands, timeout counter, read data.
  always_ff @(posedge clock) begin
    if (reset) begin
      dmemReq   <= 1'b0;
      dmemWe    <= 1'b0;
      dmemAddr  <= 32'h0;
      dmemWdata <= 32'h0;
      data_q    <= 32'h0;
      cnt       <= 16'h0;
      memError  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (mem_op) begin
            dmemReq   <= 1'b1;
            dmemWe    <= memWrite;
            dmemAddr  <= addr;
            dmemWdata <= wdata;
            cnt       <= 16'h0;
          end
        end
        S_WAIT: begin
          // Ack beats a timeout landing in the same cycle.
          if (dmemAck) begin
            dmemReq <= 1'b0;
            data_q  <= dmemWe ? 32'h0 : dmemRdata;
          end else if (timeout_hit) begin
            dmemReq  <= 1'b0;
            memError <= 1'b1;
          end else begin
            cnt <= cnt + 16'h1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_pipeline_mem_access_ctrl.sv
// Self-checking bench for mips_pipeline_mem_access_ctrl: directed scenarios plus
// randomized transactions checked against a cycle-count reference model.
module tb_mips_pipeline_mem_access_ctrl;

  localparam int TO = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        exMemValid, memRead, memWrite;
  logic [31:0] addr, wdata;
  logic        dmemReq, dmemWe;
  logic [31:0] dmemAddr, dmemWdata;
  logic        dmemAck;
  logic [31:0] dmemRdata;
  logic        stall, memWbBubble;
  logic [31:0] memOut;
  logic        memError;

  int   total = 0;
  int   bad = 0;
  int   req_rises = 0;
  logic req_q = 1'b0;

  mips_pipeline_mem_access_ctrl #(.TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .exMemValid(exMemValid), .memRead(memRead), .memWrite(memWrite),
    .addr(addr), .wdata(wdata),
    .dmemReq(dmemReq), .dmemWe(dmemWe), .dmemAddr(dmemAddr), .dmemWdata(dmemWdata),
    .dmemAck(dmemAck), .dmemRdata(dmemRdata),
    .stall(stall), .memWbBubble(memWbBubble), .memOut(memOut), .memError(memError)
  );

  always #5 clock = ~clock;

  // Count memory requests as rising edges of dmemReq, sampled mid-cycle.
  always @(negedge clock) begin
    if (dmemReq && !req_q) req_rises++;
    req_q <= dmemReq;
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Reference model of one memory instruction: 1 detect cycle + k WAIT cycles
  // (ack on the k-th), then one DONE cycle delivering read data (0 for writes).
  task automatic do_mem(input logic wr, input logic both, input logic [31:0] a,
                        input logic [31:0] d, input int k, input logic [31:0] rdat);
    logic [31:0] exp_out;
    exp_out    = wr ? 32'h0 : rdat;
    exMemValid = 1'b1;
    memWrite   = wr;
    memRead    = wr ? both : 1'b1;
    addr       = a;
    wdata      = d;
    dmemAck    = 1'b0;
    dmemRdata  = $urandom;
    #1;
    total++;
    if ({stall, memWbBubble, dmemReq, memError} !== 4'b1100) begin
      bad++;
      $display("FAIL mem_detect ctl got=%b exp=1100 addr=%h", {stall, memWbBubble, dmemReq, memError}, a);
    end
    cyc();
    for (int i = 1; i <= k; i++) begin
      dmemAck   = (i == k);
      dmemRdata = (i == k) ? rdat : $urandom;
      addr      = $urandom;
      wdata     = $urandom;
      #1;
      total++;
      if ({stall, memWbBubble, dmemReq, memError} !== 4'b1110) begin
        bad++;
        $display("FAIL mem_wait ctl cycle=%0d got=%b exp=1110", i, {stall, memWbBubble, dmemReq, memError});
      end
      total++;
      if ({dmemWe, dmemAddr, dmemWdata} !== {wr, a, d}) begin
        bad++;
        $display("FAIL mem_wait_latch cycle=%0d got we=%b a=%h d=%h exp we=%b a=%h d=%h",
                 i, dmemWe, dmemAddr, dmemWdata, wr, a, d);
      end
      cyc();
    end
    dmemAck   = 1'b0;
    dmemRdata = $urandom;
    addr      = a;
    wdata     = d;
    #1;
    total++;
    if ({stall, memWbBubble, dmemReq, memError} !== 4'b0000) begin
      bad++;
      $display("FAIL mem_done ctl got=%b exp=0000", {stall, memWbBubble, dmemReq, memError});
    end
    total++;
    if (memOut !== exp_out) begin
      bad++;
      $display("FAIL mem_done memOut got=%h exp=%h", memOut, exp_out);
    end
    cyc();
  endtask

  task automatic go_idle();
    exMemValid = 1'b0;
    memRead    = 1'b0;
    memWrite   = 1'b0;
    dmemAck    = 1'b0;
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    go_idle();
    dmemAck    = 1'b1;
    addr       = 32'hFFFF_FFFF;
    wdata      = 32'hFFFF_FFFF;
    dmemRdata  = 32'hFFFF_FFFF;
    repeat (2) cyc();
    reset = 1'b0;
    #1;
    total++;
    if ({stall, memWbBubble, dmemReq, memError, dmemWe} !== 5'b00000) begin
      bad++;
      $display("FAIL reset ctl got=%b exp=00000", {stall, memWbBubble, dmemReq, memError, dmemWe});
    end
    total++;
    if ({dmemAddr, dmemWdata, memOut} !== 96'h0) begin
      bad++;
      $display("FAIL reset data got a=%h d=%h out=%h exp 0", dmemAddr, dmemWdata, memOut);
    end
    cyc();
    total++;
    if ({stall, dmemReq, memError} !== 3'b000) begin
      bad++;
      $display("FAIL reset_stale_ack ctl got=%b exp=000", {stall, dmemReq, memError});
    end
    dmemAck = 1'b0;
  endtask

  task automatic test_nonmem(input int n);
    for (int i = 0; i < n; i++) begin
      exMemValid = $urandom_range(0, 1);
      memRead    = exMemValid ? 1'b0 : 1'($urandom_range(0, 1));
      memWrite   = exMemValid ? 1'b0 : 1'($urandom_range(0, 1));
      addr       = $urandom;
      wdata      = $urandom;
      dmemAck    = 1'b0;
      #1;
      total++;
      if ({stall, memWbBubble, dmemReq, memError} !== 4'b0000 || memOut !== 32'h0) begin
        bad++;
        $display("FAIL nonmem cycle=%0d ctl got=%b exp=0000 memOut got=%h exp=0",
                 i, {stall, memWbBubble, dmemReq, memError}, memOut);
      end
      cyc();
    end
    go_idle();
  endtask

  task automatic test_back_to_back();
    int r0;
    r0 = req_rises;
    do_mem(1'b0, 1'b0, 32'h100, 32'h0, 1, 32'hA5A5_0001);
    do_mem(1'b0, 1'b0, 32'h104, 32'h0, 1, 32'h5A5A_0002);
    go_idle();
    repeat (2) cyc();
    total++;
    if (req_rises - r0 !== 2) begin
      bad++;
      $display("FAIL back_to_back requests got=%0d exp=2", req_rises - r0);
    end
  endtask

  task automatic test_timeout();
    exMemValid = 1'b1;
    memRead    = 1'b1;
    memWrite   = 1'b0;
    addr       = 32'h300;
    dmemAck    = 1'b0;
    #1;
    total++;
    if ({stall, memWbBubble, dmemReq, memError} !== 4'b1100) begin
      bad++;
      $display("FAIL timeout_detect ctl got=%b exp=1100", {stall, memWbBubble, dmemReq, memError});
    end
    cyc();
    for (int i = 1; i <= TO; i++) begin
      #1;
      total++;
      if ({stall, memWbBubble, dmemReq, memError} !== 4'b1110) begin
        bad++;
        $display("FAIL timeout_wait cycle=%0d ctl got=%b exp=1110", i, {stall, memWbBubble, dmemReq, memError});
      end
      cyc();
    end
    for (int i = 0; i < 3; i++) begin
      dmemAck   = (i == 0);
      dmemRdata = 32'hBAD0_BAD0;
      #1;
      total++;
      if ({stall, memWbBubble, dmemReq, memError} !== 4'b1101) begin
        bad++;
        $display("FAIL timeout_err cycle=%0d ctl got=%b exp=1101", i, {stall, memWbBubble, dmemReq, memError});
      end
      cyc();
    end
    go_idle();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    #1;
    total++;
    if ({stall, memWbBubble, dmemReq, memError, dmemWe} !== 5'b00000 || dmemAddr !== 32'h0) begin
      bad++;
      $display("FAIL timeout_reset ctl got=%b exp=00000 addr got=%h exp=0",
               {stall, memWbBubble, dmemReq, memError, dmemWe}, dmemAddr);
    end
  endtask

  task automatic test_reset_mid_wait();
    exMemValid = 1'b1;
    memRead    = 1'b1;
    memWrite   = 1'b0;
    addr       = 32'h400;
    dmemAck    = 1'b0;
    cyc();
    #1;
    total++;
    if ({stall, dmemReq} !== 2'b11) begin
      bad++;
      $display("FAIL midwait_w1 got=%b exp=11", {stall, dmemReq});
    end
    cyc();
    reset = 1'b1;
    cyc();
    reset      = 1'b0;
    exMemValid = 1'b0;
    dmemAck    = 1'b1;
    dmemRdata  = 32'hCAFE_F00D;
    #1;
    total++;
    if ({stall, memWbBubble, dmemReq, memError} !== 4'b0000 || memOut !== 32'h0 || dmemAddr !== 32'h0) begin
      bad++;
      $display("FAIL midwait_after_reset ctl got=%b exp=0000 out=%h addr=%h exp 0",
               {stall, memWbBubble, dmemReq, memError}, memOut, dmemAddr);
    end
    cyc();
    dmemAck = 1'b0;
    #1;
    total++;
    if ({stall, dmemReq} !== 2'b00 || memOut !== 32'h0) begin
      bad++;
      $display("FAIL midwait_ack_ignored ctl got=%b exp=00 out=%h exp=0", {stall, dmemReq}, memOut);
    end
    cyc();
  endtask

  task automatic test_random(input int n);
    int op;
    for (int t = 0; t < n; t++) begin
      op = $urandom_range(0, 3);
      if (op == 0) test_nonmem($urandom_range(1, 2));
      else do_mem(op >= 2, op == 3, $urandom, $urandom, $urandom_range(1, TO), $urandom);
      if ($urandom_range(0, 1) == 1) go_idle();
    end
    go_idle();
    cyc();
  endtask

  initial begin
    test_reset();
    test_nonmem(5);
    do_mem(1'b0, 1'b0, 32'h100, 32'h0, 1, 32'hDEAD_BEEF);
    go_idle();
    do_mem(1'b1, 1'b0, 32'h2004, 32'h1234_5678, 3, 32'h0BAD_F00D);
    go_idle();
    do_mem(1'b0, 1'b0, 32'h208, 32'h0, TO, 32'h7777_8888);
    go_idle();
    test_back_to_back();
    test_random(40);
    test_timeout();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
